microseq_unit: RTL and testbench

MICROSEQ_UNIT -- requirements
Module: microseq_unit

---
 rtl/microseq_unit_if.sv | 42 ++++
 rtl/microseq_unit.sv | 212 +++++++++++++++++++++
 tb/tb_microseq_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/microseq_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : microseq_unit_if
//  Purpose  : Bundle of the micro-sequencer's datapath-facing signals:
//             ALU flags, interrupt request, stall, opcode, microcode ROM
//             address/data, micro-PC, control word and stack error flag.
//  Modports : master - the sequencer (drives rom_addr, upc, uinstruction,
//                      stack_err; receives everything else)
//             slave  - the surrounding datapath / ROM
//  Revision : 1.0 - initial release
// ============================================================================
interface microseq_unit_if #(
    parameter int OPC_W = 5,
    parameter int UPC_W = 4,
    parameter int UW    = 21
);
    localparam int RW = UW + UPC_W + 6;

    logic                   int_req;      // interrupt request level
    logic                   Z;            // ALU zero flag
    logic                   N;            // ALU negative flag
    logic                   C;            // ALU carry flag
    logic                   P;            // ALU parity flag
    logic                   stall;        // freeze sequencer this cycle
    logic [OPC_W-1:0]       opcode;       // current macro-instruction opcode
    logic [RW-1:0]          rom_data;     // microcode word at rom_addr
    logic [OPC_W+UPC_W-1:0] rom_addr;     // {opcode, upc}
    logic [UPC_W-1:0]       upc;          // registered micro-PC
    logic [UW-1:0]          uinstruction; // control word to datapath
    logic                   stack_err;    // sticky micro-stack error

    modport master (
        input  int_req, Z, N, C, P, stall, opcode, rom_data,
        output rom_addr, upc, uinstruction, stack_err
    );

    modport slave (
        output int_req, Z, N, C, P, stall, opcode, rom_data,
        input  rom_addr, upc, uinstruction, stack_err
    );
endinterface
`default_nettype wire

// File: rtl/microseq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : microseq_unit
//  Purpose  : Microprogram sequencer. Each cycle the word at {opcode, upc}
//             is decoded: its control-word field goes to the datapath and
//             its op/jcond/target fields choose the next micro-PC (next,
//             conditional jump, call, return, fetch, hold). Subroutine
//             returns use a small LIFO stack with a sticky error flag.
//  Ports    : clk  - clock, all state on rising edge
//             rst  - synchronous active-high reset
//             bus  - microseq_unit_if.master (flags, int, stall, opcode,
//                    rom_data in; rom_addr, upc, uinstruction, stack_err out)
//  Revision : 1.0 - initial release
// ============================================================================
module microseq_unit #(
    parameter int OPC_W   = 5,
    parameter int UPC_W   = 4,
    parameter int UW      = 21,
    parameter int STACK_D = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    microseq_unit_if.master     bus
);
    localparam int RW   = UW + UPC_W + 6;
    localparam int SP_W = $clog2(STACK_D + 1);

    localparam logic [2:0] c_OP_NEXT  = 3'b000;
    localparam logic [2:0] c_OP_JUMP  = 3'b001;
    localparam logic [2:0] c_OP_CALL  = 3'b010;
    localparam logic [2:0] c_OP_RET   = 3'b011;
    localparam logic [2:0] c_OP_FETCH = 3'b100;
    localparam logic [2:0] c_OP_HOLD  = 3'b101;

    localparam logic [2:0] c_JC_INT   = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [UPC_W-1:0] r_upc;
    logic [SP_W-1:0]  r_sp;
    logic             r_int_pend;
    logic             r_stack_err;
    logic [UPC_W-1:0] r_stack [STACK_D];

    // ------------------------------------------------------------------
    // Microcode word fields
    // ------------------------------------------------------------------
    logic [UW-1:0]    w_uinstr;
    logic [2:0]       w_op;
    logic [2:0]       w_jcond;
    logic [UPC_W-1:0] w_target;

    assign w_uinstr = bus.rom_data[RW-1:UPC_W+6];
    assign w_op     = bus.rom_data[UPC_W+5:UPC_W+3];
    assign w_jcond  = bus.rom_data[UPC_W+2:UPC_W];
    assign w_target = bus.rom_data[UPC_W-1:0];

    // ------------------------------------------------------------------
    // Condition select
    // ------------------------------------------------------------------
    logic w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (w_jcond)
            3'd1:    w_cond = 1'b1;
            3'd2:    w_cond = bus.Z;
            3'd3:    w_cond = bus.N;
            3'd4:    w_cond = bus.C;
            3'd5:    w_cond = bus.P;
            3'd6:    w_cond = r_int_pend;
            default: w_cond = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Stack top read: entry sp-1, selected by comparison so the index
    // never needs a width conversion for non-power-of-two depths.
    // ------------------------------------------------------------------
    logic [UPC_W-1:0] w_top;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (r_sp == SP_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    logic w_empty;
    logic w_full;

    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == SP_W'(STACK_D));

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    logic [UPC_W-1:0] w_upc_inc;
    logic [UPC_W-1:0] w_upc_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_clear;
    logic             w_err_set;
    logic             w_int_clr;

    assign w_upc_inc = r_upc + UPC_W'(1);

    always_comb begin
        w_upc_nxt = r_upc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_clear   = 1'b0;
        w_err_set = 1'b0;
        w_int_clr = 1'b0;
        if (!bus.stall) begin
            case (w_op)
                c_OP_JUMP: begin
                    w_upc_nxt = w_cond ? w_target : w_upc_inc;
                    w_int_clr = w_cond && (w_jcond == c_JC_INT);
                end
                c_OP_CALL: begin
                    if (w_cond) begin
                        w_upc_nxt = w_target;
                        w_int_clr = (w_jcond == c_JC_INT);
                        // A full stack still branches; only the push is lost.
                        if (w_full) begin
                            w_err_set = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else begin
                        w_upc_nxt = w_upc_inc;
                    end
                end
                c_OP_RET: begin
                    if (w_empty) begin
                        w_upc_nxt = '0;
                        w_err_set = 1'b1;
                    end else begin
                        w_upc_nxt = w_top;
                        w_pop     = 1'b1;
                    end
                end
                c_OP_FETCH: begin
                    w_upc_nxt = '0;
                    w_clear   = 1'b1;
                end
                c_OP_HOLD: begin
                    w_upc_nxt = r_upc;
                end
                // NEXT and the two unused encodings all advance.
                default: begin
                    w_upc_nxt = w_upc_inc;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upc       <= '0;
            r_sp        <= '0;
            r_int_pend  <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_upc <= w_upc_nxt;
            if (w_clear) begin
                r_sp <= '0;
            end else if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
            // A new request in the same cycle as a consuming branch wins.
            if (bus.int_req) begin
                r_int_pend <= 1'b1;
            end else if (w_int_clr) begin
                r_int_pend <= 1'b0;
            end
        end
    end

    // Stack storage needs no reset: entries above sp are never read.
    generate
        for (genvar g = 0; g < STACK_D; g++) begin : g_stack
            always_ff @(posedge clk) begin
                if (!rst && w_push && (r_sp == SP_W'(g))) begin
                    r_stack[g] <= w_upc_inc;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rom_addr     = {bus.opcode, r_upc};
    assign bus.upc          = r_upc;
    assign bus.uinstruction = bus.stall ? '0 : w_uinstr;
    assign bus.stack_err    = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_microseq_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microseq_unit
//  Purpose  : Self-checking bench for microseq_unit. Each step drives one
//             microcode word; the expected control word and next micro-PC
//             are queued at drive time and popped when the DUT shows them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_microseq_unit;
    localparam int OPC_W   = 5;
    localparam int UPC_W   = 4;
    localparam int UW      = 21;
    localparam int STACK_D = 4;

    localparam int c_NEXT  = 0;
    localparam int c_JUMP  = 1;
    localparam int c_CALL  = 2;
    localparam int c_RET   = 3;
    localparam int c_FETCH = 4;
    localparam int c_HOLD  = 5;

    logic clk;
    logic rst;

    microseq_unit_if #(.OPC_W(OPC_W), .UPC_W(UPC_W), .UW(UW)) bus ();

    microseq_unit #(
        .OPC_W  (OPC_W),
        .UPC_W  (UPC_W),
        .UW     (UW),
        .STACK_D(STACK_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp;
    int          n_err;
    int          m_cur;
    logic [31:0] q_uw  [$];
    logic [31:0] q_upc [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One sequencer cycle: drive word, check combinational outputs, then
    // check the registered micro-PC and error flag after the edge.
    task automatic step(input int op, input int jc, input int tgt, input logic stl,
                        input logic irq, input int exp_next, input logic exp_err);
        logic [UW-1:0] uw;
        uw           = UW'($urandom);
        bus.rom_data = {uw, op[2:0], jc[2:0], tgt[UPC_W-1:0]};
        bus.stall    = stl;
        bus.int_req  = irq;
        q_uw.push_back(stl ? 32'd0 : 32'(uw));
        q_upc.push_back(32'(exp_next));
        #1;
        chk("uinstruction", 32'(bus.uinstruction), q_uw.pop_front());
        chk("rom_addr", 32'(bus.rom_addr), 32'({bus.opcode, m_cur[UPC_W-1:0]}));
        @(posedge clk);
        #1;
        chk("upc", 32'(bus.upc), q_upc.pop_front());
        chk("stack_err", 32'(bus.stack_err), 32'(exp_err));
        m_cur       = exp_next;
        bus.int_req = 1'b0;
    endtask

    task automatic reset_dut();
        logic [UW-1:0] uw;
        uw           = UW'($urandom);
        rst          = 1'b1;
        bus.stall    = 1'b0;
        bus.int_req  = 1'b0;
        bus.opcode   = OPC_W'($urandom);
        bus.rom_data = {uw, 3'b001, 3'b001, 4'b0101};
        @(posedge clk);
        #1;
        chk("rst_upc", 32'(bus.upc), 32'd0);
        chk("rst_stack_err", 32'(bus.stack_err), 32'd0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'({bus.opcode, 4'b0000}));
        chk("rst_uinstruction", 32'(bus.uinstruction), 32'(uw));
        rst   = 1'b0;
        m_cur = 0;
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        m_cur        = 0;
        rst          = 1'b1;
        bus.int_req  = 1'b0;
        bus.Z        = 1'b0;
        bus.N        = 1'b0;
        bus.C        = 1'b0;
        bus.P        = 1'b0;
        bus.stall    = 1'b0;
        bus.opcode   = '0;
        bus.rom_data = '0;
        @(posedge clk);
        #1;
        reset_dut();

        // Sequential stepping with wrap; unused op encodings act as NEXT.
        for (int i = 0; i < 17; i++) begin
            step((i % 5 == 4) ? 6 + (i % 2) : c_NEXT, 0, 0, 1'b0, 1'b0, (i + 1) % 16, 1'b0);
        end

        // Conditional jumps on each flag source.
        reset_dut();
        bus.Z = 1'b0; step(c_JUMP, 2, 9, 1'b0, 1'b0, 1, 1'b0);
        bus.Z = 1'b1; step(c_JUMP, 2, 9, 1'b0, 1'b0, 9, 1'b0);
        bus.Z = 1'b0; bus.N = 1'b1;
        step(c_JUMP, 3, 2, 1'b0, 1'b0, 2, 1'b0);
        step(c_JUMP, 0, 7, 1'b0, 1'b0, 3, 1'b0);
        step(c_JUMP, 7, 7, 1'b0, 1'b0, 4, 1'b0);
        bus.C = 1'b1; step(c_JUMP, 4, 3, 1'b0, 1'b0, 3, 1'b0);
        bus.P = 1'b0; step(c_JUMP, 5, 12, 1'b0, 1'b0, 4, 1'b0);
        bus.P = 1'b1; step(c_JUMP, 5, 12, 1'b0, 1'b0, 12, 1'b0);
        step(c_HOLD, 1, 3, 1'b0, 1'b0, 12, 1'b0);
        bus.N = 1'b0; bus.C = 1'b0; bus.P = 1'b0;
        // FETCH empties the stack, so the following RET underflows.
        step(c_CALL, 1, 5, 1'b0, 1'b0, 5, 1'b0);
        step(c_FETCH, 1, 9, 1'b0, 1'b0, 0, 1'b0);
        step(c_RET, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 1, 1'b1);

        // Call / return, then a not-taken call followed by an empty return.
        reset_dut();
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 1, 1'b0);
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 2, 1'b0);
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 3, 1'b0);
        step(c_CALL, 1, 8, 1'b0, 1'b0, 8, 1'b0);
        step(c_RET, 0, 0, 1'b0, 1'b0, 4, 1'b0);
        bus.Z = 1'b0;
        step(c_CALL, 2, 1, 1'b0, 1'b0, 5, 1'b0);
        step(c_RET, 0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Nesting past the stack depth.
        reset_dut();
        step(c_CALL, 1, 5, 1'b0, 1'b0, 5, 1'b0);
        step(c_CALL, 1, 10, 1'b0, 1'b0, 10, 1'b0);
        step(c_CALL, 1, 2, 1'b0, 1'b0, 2, 1'b0);
        step(c_CALL, 1, 14, 1'b0, 1'b0, 14, 1'b0);
        step(c_CALL, 1, 7, 1'b0, 1'b0, 7, 1'b1);
        step(c_RET, 0, 0, 1'b0, 1'b0, 3, 1'b1);
        step(c_RET, 0, 0, 1'b0, 1'b0, 11, 1'b1);
        step(c_RET, 0, 0, 1'b0, 1'b0, 6, 1'b1);
        step(c_RET, 0, 0, 1'b0, 1'b0, 1, 1'b1);
        step(c_RET, 0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Stall with an interrupt pulse, then interrupt-conditioned jumps.
        reset_dut();
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 1, 1'b0);
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 2, 1'b0);
        step(c_JUMP, 1, 9, 1'b1, 1'b1, 2, 1'b0);
        step(c_RET, 0, 0, 1'b1, 1'b0, 2, 1'b0);
        step(c_CALL, 1, 5, 1'b1, 1'b0, 2, 1'b0);
        step(c_JUMP, 6, 11, 1'b0, 1'b0, 11, 1'b0);
        step(c_JUMP, 6, 5, 1'b0, 1'b0, 12, 1'b0);
        step(c_JUMP, 6, 5, 1'b0, 1'b1, 13, 1'b0);
        step(c_JUMP, 6, 2, 1'b0, 1'b1, 2, 1'b0);
        step(c_JUMP, 6, 8, 1'b0, 1'b0, 8, 1'b0);
        step(c_JUMP, 6, 0, 1'b0, 1'b0, 9, 1'b0);

        // Reset in the middle of a subroutine while stalled.
        reset_dut();
        step(c_CALL, 1, 6, 1'b0, 1'b0, 6, 1'b0);
        step(c_CALL, 1, 9, 1'b0, 1'b0, 9, 1'b0);
        step(c_NEXT, 0, 0, 1'b0, 1'b1, 10, 1'b0);
        rst          = 1'b1;
        bus.stall    = 1'b1;
        bus.rom_data = {UW'($urandom), 3'b010, 3'b001, 4'b0011};
        @(posedge clk);
        #1;
        chk("rst_stall_upc", 32'(bus.upc), 32'd0);
        chk("rst_stall_err", 32'(bus.stack_err), 32'd0);
        chk("rst_stall_uinstr", 32'(bus.uinstruction), 32'd0);
        rst   = 1'b0;
        m_cur = 0;
        step(c_JUMP, 6, 7, 1'b0, 1'b0, 1, 1'b0);
        step(c_RET, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(c_NEXT, 0, 0, 1'b0, 1'b0, 1, 1'b1);
        reset_dut();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
